// File: rtl/audio_pkg.sv
// Audio sample types and I2S timing constants for the DAC output stage.
`include "constants.svh"

package audio_pkg;
    localparam int SAMPLE_WIDTH = `SAMPLE_WIDTH;
    localparam int SLOT_BITS    = 32;
    localparam int BCLK_HALF    = 16;
    localparam int MCLK_HALF    = 2;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
    typedef logic [SLOT_BITS-1:0]           slot_word_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_sample_t;

    // Right-justified slot word: sample sign bit replicated into the upper slot bits.
    function automatic slot_word_t sign_extend(input sample_t s);
        return slot_word_t'(s);
    endfunction
endpackage

// File: rtl/i2s_serializer_if.sv
// Stereo sample handshake between the mixer chain and the I2S output stage.
interface i2s_serializer_if;
    import audio_pkg::*;

    logic    in_valid;
    logic    in_ready;
    sample_t in_left;
    sample_t in_right;

    modport master (output in_valid, output in_left, output in_right, input in_ready);
    modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/constants.svh
// Datapath-wide widths shared by the synth audio chain.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH
`define SAMPLE_WIDTH 24
`endif

// File: rtl/i2s_clkgen.sv
// Integer dividers for the DAC master and bit clocks, plus a bit-clock falling-edge strobe.
module i2s_clkgen #(
    parameter int MCLK_HALF = 2,
    parameter int BCLK_HALF = 16
) (
    input  logic clk,
    input  logic rst,
    output logic sys_clk,
    output logic bit_clk,
    output logic bclk_fall
);
    localparam int MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int BW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [MW-1:0] M_LAST = MW'(MCLK_HALF - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BCLK_HALF - 1);

    logic [MW-1:0] mclk_cnt_q, mclk_cnt_d;
    logic [BW-1:0] bclk_cnt_q, bclk_cnt_d;
    logic          sys_clk_q, sys_clk_d;
    logic          bit_clk_q, bit_clk_d;
    logic          m_wrap, b_wrap;

    always_comb begin
        m_wrap     = (mclk_cnt_q == M_LAST);
        b_wrap     = (bclk_cnt_q == B_LAST);
        mclk_cnt_d = m_wrap ? '0 : mclk_cnt_q + MW'(1);
        bclk_cnt_d = b_wrap ? '0 : bclk_cnt_q + BW'(1);
        sys_clk_d  = m_wrap ? ~sys_clk_q : sys_clk_q;
        bit_clk_d  = b_wrap ? ~bit_clk_q : bit_clk_q;
        // Strobe marks the clk cycle whose edge drives bit_clk low.
        bclk_fall  = !rst && b_wrap && bit_clk_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mclk_cnt_q <= '0;
            bclk_cnt_q <= '0;
            sys_clk_q  <= 1'b0;
            bit_clk_q  <= 1'b0;
        end else begin
            mclk_cnt_q <= mclk_cnt_d;
            bclk_cnt_q <= bclk_cnt_d;
            sys_clk_q  <= sys_clk_d;
            bit_clk_q  <= bit_clk_d;
        end
    end

    assign sys_clk = sys_clk_q;
    assign bit_clk = bit_clk_q;
endmodule

// File: rtl/i2s_serializer.sv
// I2S output stage: single-entry holding register, frame bit counter and slot serializer.
module i2s_serializer
    import audio_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    i2s_serializer_if.slave         in_if,
    output logic                    underrun,
    output logic                    dac_sys_clk,
    output logic                    dac_bit_clk,
    output logic                    dac_lr_clk,
    output logic                    dac_data
);
    localparam int CNT_W = $clog2(2 * SLOT_BITS);
    localparam int IDX_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_BITS);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(SLOT_BITS - 1);

    logic           bclk_fall;
    stereo_sample_t hold_q, hold_d;
    logic           hold_full_q, hold_full_d;
    slot_word_t     left_sr_q, left_sr_d;
    slot_word_t     right_sr_q, right_sr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, slot_pos;
    logic [IDX_W-1:0] bit_idx;
    logic           lr_q, lr_d;
    logic           data_q, data_d;
    logic           accept, frame_start;

    i2s_clkgen #(
        .MCLK_HALF(MCLK_HALF),
        .BCLK_HALF(BCLK_HALF)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .sys_clk   (dac_sys_clk),
        .bit_clk   (dac_bit_clk),
        .bclk_fall (bclk_fall)
    );

    assign in_if.in_ready = !hold_full_q;

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        left_sr_d   = left_sr_q;
        right_sr_d  = right_sr_q;
        bit_cnt_d   = bit_cnt_q;
        lr_d        = lr_q;
        data_d      = data_q;

        accept      = in_if.in_valid && !hold_full_q;
        frame_start = bclk_fall && (bit_cnt_q == CNT_LAST);
        underrun    = frame_start && !hold_full_q;

        if (bclk_fall) begin
            bit_cnt_d = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
        end

        // An empty holding register leaves the shift registers alone, so the last pair repeats.
        if (frame_start && hold_full_q) begin
            left_sr_d   = sign_extend(hold_q.left);
            right_sr_d  = sign_extend(hold_q.right);
            hold_full_d = 1'b0;
        end

        if (accept) begin
            hold_d.left  = in_if.in_left;
            hold_d.right = in_if.in_right;
            hold_full_d  = 1'b1;
        end

        slot_pos = (bit_cnt_d >= SLOT_CNT) ? bit_cnt_d - SLOT_CNT : bit_cnt_d;
        bit_idx  = IDX_TOP - IDX_W'(slot_pos);

        if (bclk_fall) begin
            lr_d   = (bit_cnt_d < SLOT_CNT);
            data_d = lr_d ? left_sr_d[bit_idx] : right_sr_d[bit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            left_sr_q   <= '0;
            right_sr_q  <= '0;
            bit_cnt_q   <= CNT_LAST;
            lr_q        <= 1'b0;
            data_q      <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            left_sr_q   <= left_sr_d;
            right_sr_q  <= right_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            lr_q        <= lr_d;
            data_q      <= data_d;
        end
    end

    assign dac_lr_clk = lr_q;
    assign dac_data   = data_q;
endmodule

// File: tb/tb_i2s_serializer.sv
// Directed bench for i2s_serializer: clock timing, I2S decode, back-pressure, underrun, reset abort.
module tb_i2s_serializer;
    localparam int SW = audio_pkg::SAMPLE_WIDTH;

    logic clk = 1'b0;
    logic rst;
    logic underrun, dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data;

    i2s_serializer_if u_if();

    i2s_serializer u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_if       (u_if),
        .underrun    (underrun),
        .dac_sys_clk (dac_sys_clk),
        .dac_bit_clk (dac_bit_clk),
        .dac_lr_clk  (dac_lr_clk),
        .dac_data    (dac_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // cyc = number of clk rising edges since reset release
    int cyc;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int acc_q[$];
    always @(posedge clk) begin
        if (rst) acc_q.delete();
        else if (u_if.in_valid && u_if.in_ready) acc_q.push_back(cyc + 1);
    end

    logic prev_sys = 1'b0, prev_bclk = 1'b0, prev_lr = 1'b0;
    int t_sys_rise, sys_period, t_bclk_rise, t_bclk_rise1, t_bclk_fall1, bclk_period;
    int t_lr_rise, t_lr_rise1, lr_period, lr_high;
    logic [31:0] sr, left_cap;
    logic have_left;
    logic [31:0] dec_l[$], dec_r[$];
    int ur_q[$];

    always @(negedge clk) begin
        prev_sys  <= dac_sys_clk;
        prev_bclk <= dac_bit_clk;
        prev_lr   <= dac_lr_clk;
        if (rst) begin
            t_sys_rise <= -1; sys_period <= -1;
            t_bclk_rise <= -1; t_bclk_rise1 <= -1; t_bclk_fall1 <= -1; bclk_period <= -1;
            t_lr_rise <= -1; t_lr_rise1 <= -1; lr_period <= -1; lr_high <= -1;
            sr <= '0; left_cap <= '0; have_left <= 1'b0;
            dec_l.delete(); dec_r.delete(); ur_q.delete();
        end else begin
            if (dac_sys_clk && !prev_sys) begin
                if (t_sys_rise >= 0) sys_period <= cyc - t_sys_rise;
                t_sys_rise <= cyc;
            end
            if (dac_bit_clk && !prev_bclk) begin
                if (t_bclk_rise1 < 0) t_bclk_rise1 <= cyc;
                if (t_bclk_rise >= 0) bclk_period <= cyc - t_bclk_rise;
                t_bclk_rise <= cyc;
                sr <= {sr[30:0], dac_data};
            end
            if (!dac_bit_clk && prev_bclk && t_bclk_fall1 < 0) t_bclk_fall1 <= cyc;
            if (dac_lr_clk && !prev_lr) begin
                if (t_lr_rise1 < 0) t_lr_rise1 <= cyc;
                if (t_lr_rise >= 0) lr_period <= cyc - t_lr_rise;
                t_lr_rise <= cyc;
                if (have_left) begin
                    dec_l.push_back(left_cap);
                    dec_r.push_back(sr);
                end
            end
            if (!dac_lr_clk && prev_lr) begin
                lr_high   <= cyc - t_lr_rise;
                left_cap  <= sr;
                have_left <= 1'b1;
            end
            if (underrun) ur_q.push_back(cyc + 1);
        end
    end

    task automatic send_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
        int n = 0;
        u_if.in_valid = 1'b1;
        u_if.in_left  = l;
        u_if.in_right = r;
        while (!u_if.in_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(u_if.in_ready), 32'd1);
        @(negedge clk);
        u_if.in_valid = 1'b0;
    endtask

    task automatic wait_until(input int target);
        int n = 0;
        while (cyc != target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("wait_cycle", 32'(cyc), 32'(target));
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({dac_sys_clk, dac_bit_clk, dac_lr_clk, dac_data, underrun, u_if.in_ready});
    endfunction

    logic [31:0] exp_l [7] = '{32'h00123456, 32'h1, 32'h3, 32'h007FFFFF, 32'h007FFFFF, 32'h007FFFFF, 32'h007FFFFF};
    logic [31:0] exp_r [7] = '{32'hFFFFFFFB, 32'h2, 32'h4, 32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000};
    int exp_acc [6] = '{1, 33, 2081, 4129, 12320, 14369};
    int exp_ur  [3] = '{8224, 10272, 12320};

    initial begin
        rst = 1'b1;
        u_if.in_valid = 1'b0;
        u_if.in_left  = '0;
        u_if.in_right = '0;
        repeat (5) @(negedge clk);
        check("reset_outputs", out_vec(), 32'h1);
        rst = 1'b0;

        send_pair(24'h123456, 24'hFFFFFB);
        check("hold_full_ready", 32'(u_if.in_ready), 32'd0);
        send_pair(24'h000001, 24'h000002);
        send_pair(24'h000003, 24'h000004);
        send_pair(24'h7FFFFF, 24'h800000);
        check("bp_ready_low", 32'(u_if.in_ready), 32'd0);

        check("sys_period", 32'(sys_period), 32'd4);
        check("bclk_rise1", 32'(t_bclk_rise1), 32'd16);
        check("bclk_fall1", 32'(t_bclk_fall1), 32'd32);
        check("bclk_period", 32'(bclk_period), 32'd32);
        check("lr_rise1", 32'(t_lr_rise1), 32'd32);
        check("lr_high", 32'(lr_high), 32'd1024);
        check("lr_period", 32'(lr_period), 32'd2048);

        wait_until(12319);
        u_if.in_valid = 1'b1;
        u_if.in_left  = 24'h0000AA;
        u_if.in_right = 24'h0000BB;
        check("sim_underrun", 32'(underrun), 32'd1);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        check("sim_ready_low", 32'(u_if.in_ready), 32'd0);

        wait_until(14368);
        send_pair(24'h000055, 24'h000066);
        wait_until(15648);

        check("dec_count", 32'(dec_l.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("dec_left%0d", i), dec_l.size() > i ? dec_l[i] : 32'hDEAD, exp_l[i]);
            check($sformatf("dec_right%0d", i), dec_r.size() > i ? dec_r[i] : 32'hDEAD, exp_r[i]);
        end
        check("acc_count", 32'(acc_q.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("acc_cycle%0d", i), acc_q.size() > i ? 32'(acc_q[i]) : 32'hDEAD, 32'(exp_acc[i]));
        check("ur_count", 32'(ur_q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("ur_cycle%0d", i), ur_q.size() > i ? 32'(ur_q[i]) : 32'hDEAD, 32'(exp_ur[i]));

        rst = 1'b1;
        @(negedge clk);
        check("midreset_outputs", out_vec(), 32'h1);
        repeat (4) @(negedge clk);
        rst = 1'b0;

        wait_until(2100);
        check("rst2_bclk_rise1", 32'(t_bclk_rise1), 32'd16);
        check("rst2_lr_rise1", 32'(t_lr_rise1), 32'd32);
        check("rst2_ur_count", 32'(ur_q.size()), 32'd2);
        check("rst2_ur_first", ur_q.size() > 0 ? 32'(ur_q[0]) : 32'hDEAD, 32'd32);
        check("rst2_acc_count", 32'(acc_q.size()), 32'd0);
        check("rst2_dec_count", 32'(dec_l.size()), 32'd1);
        check("rst2_dec_left", dec_l.size() > 0 ? dec_l[0] : 32'hDEAD, 32'h0);
        check("rst2_dec_right", dec_r.size() > 0 ? dec_r[0] : 32'hDEAD, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
